arith_bin_engine: RTL and testbench

ARITH_BIN_ENGINE -- requirements
Module: arith_bin_engine

---
 rtl/arith_bin_engine.sv | 295 +++++++++++++++++++++++++++++
 tb/tb_arith_bin_engine.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/arith_bin_engine.sv
// rtl/arith_bin_engine.sv - CABAC-style arithmetic bin decoder with input byte FIFO
module arith_bin_engine #(
    parameter int BIN_WIDTH  = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           init,
    input  logic [7:0]                     byte_in,
    input  logic                           byte_valid,
    output logic                           byte_ready,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic [1:0]                     req_mode,
    input  logic [$clog2(BIN_WIDTH+1)-1:0] req_nbin,
    input  logic [7:0]                     lps_range,
    input  logic                           mps_in,
    output logic                           bin_valid,
    output logic [BIN_WIDTH-1:0]           bin_out,
    output logic [$clog2(BIN_WIDTH+1)-1:0] bin_count,
    output logic                           busy
);

    localparam int NW = $clog2(BIN_WIDTH + 1);
    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [8:0] RANGE_INIT = 9'd510;
    localparam logic [3:0] BN_INIT    = 4'b1000;  // -8

    localparam logic [1:0] MODE_REGULAR   = 2'b00;
    localparam logic [1:0] MODE_BYPASS    = 2'b01;
    localparam logic [1:0] MODE_TERMINATE = 2'b10;
    localparam logic [1:0] MODE_RESERVED  = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        READY  = 2'd2,
        DECODE = 2'd3
    } state_t;

    // Byte FIFO
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   fifo_cnt_q;
    logic          fifo_empty, fifo_full, push, pop;
    logic [7:0]    fifo_head;

    // Decoder state and captured request
    state_t          state_q, state_d;
    logic [8:0]      range_q, range_d;
    logic [15:0]     value_q, value_d;
    logic [3:0]      bn_q, bn_d;          // two's complement bits_needed
    logic            load_cnt_q, load_cnt_d;
    logic [1:0]      mode_q, mode_d;
    logic [NW-1:0]   nbin_q, nbin_d;
    logic [7:0]      lps_q, lps_d;
    logic            mps_q, mps_d;
    logic            invalid_q, invalid_d;
    logic            bin_valid_q, bin_valid_d;
    logic [BIN_WIDTH-1:0] bin_out_q, bin_out_d;
    logic [NW-1:0]   bin_count_q, bin_count_d;

    // Single-bin datapath results
    logic        dec_bin, dec_refill;
    logic [8:0]  dec_range;
    logic [15:0] dec_value;
    logic [3:0]  dec_bn;
    logic [16:0] v17, s17;
    logic [8:0]  r_sub, r_term;
    logic [4:0]  bn_w;
    logic [3:0]  k;

    assign fifo_empty = (fifo_cnt_q == '0);
    assign fifo_full  = (fifo_cnt_q == (AW+1)'(FIFO_DEPTH));
    assign fifo_head  = fifo_mem[rd_ptr_q];
    assign byte_ready = !fifo_full;
    assign push       = byte_valid && !fifo_full && !init && !reset;

    assign req_ready = (state_q == READY);
    assign busy      = (state_q == LOAD) || (state_q == DECODE);
    assign bin_valid = bin_valid_q;
    assign bin_out   = bin_out_q;
    assign bin_count = bin_count_q;

    // Left shift that brings the MSB of r up to bit 8 (0 for r==0)
    function automatic logic [3:0] renorm_shift(input logic [8:0] r);
        logic [3:0] sh;
        sh = 4'd0;
        for (int i = 0; i < 9; i++) begin
            if (r[i]) sh = 4'(8 - i);
        end
        return sh;
    endfunction

    // FIFO storage write
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= byte_in;
    end

    // FIFO pointers and occupancy; init flushes everything
    always_ff @(posedge clk) begin
        if (reset || init) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + (AW+1)'(1);
                2'b01:   fifo_cnt_q <= fifo_cnt_q - (AW+1)'(1);
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
        end
    end

    // One bin of the captured request: shift/renorm, optional refill, bypass compare
    always_comb begin
        dec_bin    = 1'b0;
        dec_refill = 1'b0;
        dec_range  = range_q;
        v17        = {1'b0, value_q};
        bn_w       = {bn_q[3], bn_q};
        k          = 4'd0;
        r_sub      = range_q - {1'b0, lps_q};
        s17        = {1'b0, r_sub, 7'b0};
        r_term     = range_q - 9'd2;

        case (mode_q)
            MODE_REGULAR: begin
                if ({1'b0, value_q} < s17) begin
                    dec_bin   = mps_q;
                    dec_range = r_sub;
                    if (!r_sub[8]) begin
                        dec_range = {r_sub[7:0], 1'b0};
                        v17       = {value_q, 1'b0};
                        bn_w      = bn_w + 5'd1;
                    end
                end else begin
                    dec_bin   = !mps_q;
                    k         = renorm_shift({1'b0, lps_q});
                    dec_range = {1'b0, lps_q} << k;
                    v17       = ({1'b0, value_q} - s17) << k;
                    bn_w      = bn_w + {1'b0, k};
                end
            end
            MODE_BYPASS: begin
                v17  = {value_q, 1'b0};
                bn_w = bn_w + 5'd1;
            end
            MODE_TERMINATE: begin
                dec_range = r_term;
                if ({1'b0, value_q} >= {1'b0, r_term, 7'b0}) begin
                    dec_bin = 1'b1;
                end else if (!r_term[8]) begin
                    dec_range = {r_term[7:0], 1'b0};
                    v17       = {value_q, 1'b0};
                    bn_w      = bn_w + 5'd1;
                end
            end
            default: ;
        endcase

        // Refill once bits_needed has gone non-negative
        if (mode_q != MODE_RESERVED && !bn_w[4]) begin
            dec_refill = 1'b1;
            v17        = v17 + ({9'b0, fifo_head} << bn_w[2:0]);
            bn_w       = bn_w - 5'd8;
        end

        // Bypass decision is made on the refilled value
        if (mode_q == MODE_BYPASS) begin
            if (v17 >= {1'b0, range_q, 7'b0}) begin
                dec_bin = 1'b1;
                v17     = v17 - {1'b0, range_q, 7'b0};
            end
        end

        dec_value = v17[15:0];
        dec_bn    = bn_w[3:0];
    end

    // Next-state and register update logic
    always_comb begin
        state_d     = state_q;
        range_d     = range_q;
        value_d     = value_q;
        bn_d        = bn_q;
        load_cnt_d  = load_cnt_q;
        mode_d      = mode_q;
        nbin_d      = nbin_q;
        lps_d       = lps_q;
        mps_d       = mps_q;
        invalid_d   = invalid_q;
        bin_valid_d = 1'b0;
        bin_out_d   = bin_out_q;
        bin_count_d = bin_count_q;
        pop         = 1'b0;

        case (state_q)
            IDLE: ;
            LOAD: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                    if (!load_cnt_q) begin
                        value_d    = {fifo_head, value_q[7:0]};
                        load_cnt_d = 1'b1;
                    end else begin
                        value_d    = {value_q[15:8], fifo_head};
                        range_d    = RANGE_INIT;
                        bn_d       = BN_INIT;
                        load_cnt_d = 1'b0;
                        state_d    = READY;
                    end
                end
            end
            READY: begin
                if (req_valid) begin
                    mode_d      = req_mode;
                    nbin_d      = (req_mode == MODE_BYPASS) ? req_nbin : NW'(1);
                    lps_d       = lps_range;
                    mps_d       = mps_in;
                    invalid_d   = (req_mode == MODE_RESERVED) ||
                                  ((req_mode == MODE_BYPASS) &&
                                   ((req_nbin == '0) || (req_nbin > NW'(BIN_WIDTH))));
                    bin_out_d   = '0;
                    bin_count_d = '0;
                    state_d     = DECODE;
                end
            end
            DECODE: begin
                if (invalid_q) begin
                    bin_valid_d = 1'b1;
                    bin_out_d   = '0;
                    bin_count_d = '0;
                    state_d     = READY;
                end else if (!(dec_refill && fifo_empty)) begin
                    pop         = dec_refill;
                    range_d     = dec_range;
                    value_d     = dec_value;
                    bn_d        = dec_bn;
                    bin_out_d   = (bin_out_q << 1) | BIN_WIDTH'(dec_bin);
                    bin_count_d = bin_count_q + NW'(1);
                    if (bin_count_q + NW'(1) == nbin_q) begin
                        bin_valid_d = 1'b1;
                        state_d     = READY;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; reset beats init, init beats everything else
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            range_q     <= RANGE_INIT;
            value_q     <= '0;
            bn_q        <= BN_INIT;
            load_cnt_q  <= 1'b0;
            mode_q      <= '0;
            nbin_q      <= '0;
            lps_q       <= '0;
            mps_q       <= 1'b0;
            invalid_q   <= 1'b0;
            bin_valid_q <= 1'b0;
            bin_out_q   <= '0;
            bin_count_q <= '0;
        end else if (init) begin
            state_q     <= LOAD;
            load_cnt_q  <= 1'b0;
            invalid_q   <= 1'b0;
            bin_valid_q <= 1'b0;
            bin_out_q   <= '0;
            bin_count_q <= '0;
        end else begin
            state_q     <= state_d;
            range_q     <= range_d;
            value_q     <= value_d;
            bn_q        <= bn_d;
            load_cnt_q  <= load_cnt_d;
            mode_q      <= mode_d;
            nbin_q      <= nbin_d;
            lps_q       <= lps_d;
            mps_q       <= mps_d;
            invalid_q   <= invalid_d;
            bin_valid_q <= bin_valid_d;
            bin_out_q   <= bin_out_d;
            bin_count_q <= bin_count_d;
        end
    end

endmodule

// File: tb/tb_arith_bin_engine.sv
// tb/tb_arith_bin_engine.sv - scoreboard testbench for arith_bin_engine
module tb_arith_bin_engine;

    logic       clk = 1'b0;
    logic       reset, init;
    logic [7:0] byte_in;
    logic       byte_valid, byte_ready;
    logic       req_valid, req_ready;
    logic [1:0] req_mode;
    logic [2:0] req_nbin;
    logic [7:0] lps_range;
    logic       mps_in;
    logic       bin_valid;
    logic [3:0] bin_out;
    logic [2:0] bin_count;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [3:0] out;
        logic [2:0] cnt;
        int         cyc;
    } exp_t;

    exp_t sb[$];

    arith_bin_engine #(.BIN_WIDTH(4), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .init(init),
        .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
        .req_nbin(req_nbin), .lps_range(lps_range), .mps_in(mps_in),
        .bin_valid(bin_valid), .bin_out(bin_out), .bin_count(bin_count), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every bin_valid cycle must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (bin_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_bin_valid: bin_out=%0d bin_count=%0d with nothing expected", bin_out, bin_count);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("bin_out", bin_out, e.out);
                check("bin_count", bin_count, e.cnt);
                if (e.cyc >= 0) check("bin_latency_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic wait_ready(input string name);
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: req_ready=0 expected 1", name);
        end
    endtask

    task automatic send_req(input logic [1:0] mode, input logic [2:0] nbin, input logic [7:0] lps,
                            input logic mps, input logic [3:0] eo, input logic [2:0] ec,
                            input int lat, input bit expect_out);
        int n = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_mode  = mode;
        req_nbin  = nbin;
        lps_range = lps;
        mps_in    = mps;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL req_accept_timeout: req_ready=0 expected 1");
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        if (expect_out) sb.push_back('{out: eo, cnt: ec, cyc: cyc + lat});
    endtask

    task automatic do_load(input logic [7:0] b0, input logic [7:0] b1);
        @(negedge clk);
        init       = 1'b1;
        byte_valid = 1'b1;
        byte_in    = 8'hEE;
        @(negedge clk);
        init    = 1'b0;
        byte_in = b0;
        check("load_busy", busy, 1);
        check("load_state", dut.state_q, 1);
        check("init_byte_discarded", dut.fifo_cnt_q, 0);
        @(negedge clk);
        byte_in = b1;
        @(negedge clk);
        byte_valid = 1'b0;
        wait_ready("load");
    endtask

    task automatic check_core(input string tag, input int rng, input int val, input int bn);
        check({tag, "_range"}, dut.range_q, rng);
        check({tag, "_value"}, dut.value_q, val);
        check({tag, "_bits_needed"}, $signed(dut.bn_q), bn);
    endtask

    initial begin
        reset = 1'b1; init = 1'b0; byte_in = 8'h00; byte_valid = 1'b0;
        req_valid = 1'b0; req_mode = 2'b00; req_nbin = 3'd0; lps_range = 8'd0; mps_in = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Reset state after 3 idle cycles
        repeat (3) @(negedge clk);
        check("rst_bin_valid", bin_valid, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_byte_ready", byte_ready, 1);
        check("rst_bin_out", bin_out, 0);
        check("rst_bin_count", bin_count, 0);
        check("rst_state", dut.state_q, 0);
        check_core("rst", 510, 0, -8);

        // FIFO fill with no pops: 4 bytes accepted, 5th refused
        byte_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            byte_in = 8'(8'h10 + i);
            @(negedge clk);
        end
        check("full_byte_ready", byte_ready, 0);
        check("full_count", dut.fifo_cnt_q, 4);
        byte_in = 8'h55;
        @(negedge clk);
        byte_valid = 1'b0;
        check("fifth_not_taken", dut.fifo_cnt_q, 4);
        check("full_byte_ready_held", byte_ready, 0);

        // Load 0x8C,0xD1
        do_load(8'h8C, 8'hD1);
        check_core("load", 510, 36049, -8);
        check("load_req_ready", req_ready, 1);
        check("ready_busy", busy, 0);

        // Bypass, one bin
        send_req(2'b01, 3'd1, 8'd0, 1'b0, 4'b0001, 3'd1, 1, 1'b1);
        wait_ready("bypass1");
        check_core("bypass1", 510, 6818, -7);

        // Terminate, bin 0, no renorm
        do_load(8'h8C, 8'hD1);
        send_req(2'b10, 3'd1, 8'd0, 1'b0, 4'b0000, 3'd1, 1, 1'b1);
        wait_ready("term");
        check_core("term", 508, 36049, -8);

        // Regular MPS path then LPS path with 1-bit renorm
        do_load(8'h8C, 8'hD1);
        send_req(2'b00, 3'd1, 8'd100, 1'b0, 4'b0000, 3'd1, 1, 1'b1);
        wait_ready("reg_mps");
        check_core("reg_mps", 410, 36049, -8);
        send_req(2'b00, 3'd1, 8'd250, 1'b0, 4'b0001, 3'd1, 1, 1'b1);
        wait_ready("reg_lps");
        check_core("reg_lps", 500, 31138, -7);

        // Rejected requests complete immediately without touching the decoder
        send_req(2'b11, 3'd2, 8'd0, 1'b0, 4'b0000, 3'd0, 1, 1'b1);
        wait_ready("reserved");
        send_req(2'b01, 3'd0, 8'd0, 1'b0, 4'b0000, 3'd0, 1, 1'b1);
        wait_ready("bypass_n0");
        send_req(2'b01, 3'd5, 8'd0, 1'b0, 4'b0000, 3'd0, 1, 1'b1);
        wait_ready("bypass_n5");
        check_core("rejected", 500, 31138, -7);

        // Regular with nbin=3 is forced to one bin
        send_req(2'b00, 3'd3, 8'd100, 1'b1, 4'b0001, 3'd1, 1, 1'b1);
        wait_ready("reg_forced");
        check_core("reg_forced", 400, 31138, -7);

        // Two 4-bin bypass requests, second stalls on its last bin
        do_load(8'h8C, 8'hD1);
        send_req(2'b01, 3'd4, 8'd0, 1'b0, 4'b1000, 3'd4, 4, 1'b1);
        send_req(2'b01, 3'd4, 8'd0, 1'b0, 4'b0000, 3'd0, 0, 1'b0);
        repeat (6) @(negedge clk);
        check("stall_busy", busy, 1);
        check("stall_req_ready", req_ready, 0);
        check("stall_state", dut.state_q, 3);
        byte_valid = 1'b1;
        byte_in    = 8'h5A;
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
        sb.push_back('{out: 4'b1101, cnt: 3'd4, cyc: cyc + 1});
        wait_ready("stall");
        check_core("stall", 510, 24154, -8);
        check("stall_fifo_empty", dut.fifo_cnt_q, 0);

        // Init mid-request: flush, abort, back to LOAD
        send_req(2'b01, 3'd4, 8'd0, 1'b0, 4'b0000, 3'd0, 0, 1'b0);
        @(negedge clk);
        init       = 1'b1;
        byte_valid = 1'b1;
        byte_in    = 8'h77;
        @(posedge clk);
        #1;
        init       = 1'b0;
        byte_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("abort_fifo_empty", dut.fifo_cnt_q, 0);
        check("abort_state", dut.state_q, 1);
        check("abort_busy", busy, 1);
        check("abort_bin_out", bin_out, 0);
        check("abort_bin_count", bin_count, 0);

        // Reset mid-decode drops the request
        byte_valid = 1'b1;
        byte_in    = 8'h8C;
        @(negedge clk);
        byte_in = 8'hD1;
        @(negedge clk);
        byte_valid = 1'b0;
        wait_ready("reload");
        send_req(2'b01, 3'd4, 8'd0, 1'b0, 4'b0000, 3'd0, 0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        check("reset_state", dut.state_q, 0);
        check("reset_busy", busy, 0);
        check("reset_req_ready", req_ready, 0);
        check_core("reset_mid", 510, 0, -8);

        check("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
